// File: rtl/dmem_arb.sv
// dmem_arb: two-requester data-memory arbiter in front of a single-port SRAM.
//
// Requesters m0/m1 present req/wr/size/addr/wdata; the arbiter grants at most one per
// cycle (combinational gnt, alternating priority pointer), issues the access to the SRAM in
// the grant cycle, and returns a one-cycle rvalid/rdata/err response to the owner exactly
// one cycle later. A new access can be issued in the same cycle a response is returned.
//
// Parameters:
//   RESET_PRIO - requester preferred on the first contended cycle after reset (0=m0, 1=m1)
// Optional feature:
//   DMEM_ARB_ADDR_ERR_EN - when defined, misaligned half/word accesses are granted but not
//                          sent to the SRAM, and their response carries err=1, rdata=0.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   mX_req/wr/size/addr/wdata  - requester X access inputs
//   mX_gnt                     - requester X accepted this cycle
//   mX_rvalid/rdata/err        - requester X response (one cycle after its grant)
//   data_sram_en/wen/addr/wdata - SRAM access strobe, byte enables, word address, store data
//   data_sram_rdata            - SRAM read data, valid one cycle after a read strobe
module dmem_arb #(
   parameter int unsigned RESET_PRIO = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_wen,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic [31:0] data_sram_rdata
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e state_q, state_d;
   logic   prio_q, prio_d;    // preferred requester on contention (0=m0, 1=m1)
   logic   owner_q, owner_d;  // requester owed the pending response
   logic   wr_q, wr_d;
   logic   err_q, err_d;

   logic        sel;
   logic        sel_wr;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  off;
   logic [31:0] rsp_data;
`ifdef DMEM_ARB_ADDR_ERR_EN
   logic        mis;
`endif

   always_comb begin
      state_d         = StIdle;
      prio_d          = prio_q;
      owner_d         = owner_q;
      wr_d            = wr_q;
      err_d           = 1'b0;
      m0_gnt          = 1'b0;
      m1_gnt          = 1'b0;
      m0_rvalid       = 1'b0;
      m1_rvalid       = 1'b0;
      m0_rdata        = 32'h0;
      m1_rdata        = 32'h0;
      m0_err          = 1'b0;
      m1_err          = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      sel             = 1'b0;
      sel_wr          = 1'b0;
      sel_size        = 2'b00;
      sel_addr        = 32'h0;
      sel_wdata       = 32'h0;
      off             = 2'b00;
      rsp_data        = 32'h0;
`ifdef DMEM_ARB_ADDR_ERR_EN
      mis             = 1'b0;
`endif

      // Everything is suppressed while reset is high, including a response still owed.
      if (!reset) begin
         if (state_q == StBusy) begin
            rsp_data = (!wr_q && !err_q) ? data_sram_rdata : 32'h0;
            if (owner_q) begin
               m1_rvalid = 1'b1;
               m1_rdata  = rsp_data;
               m1_err    = err_q;
            end else begin
               m0_rvalid = 1'b1;
               m0_rdata  = rsp_data;
               m0_err    = err_q;
            end
         end

         if (m0_req || m1_req) begin
            sel       = (m0_req && m1_req) ? prio_q : m1_req;
            m0_gnt    = ~sel;
            m1_gnt    = sel;
            prio_d    = ~sel;
            owner_d   = sel;
            state_d   = StBusy;
            sel_wr    = sel ? m1_wr    : m0_wr;
            sel_size  = sel ? m1_size  : m0_size;
            sel_addr  = sel ? m1_addr  : m0_addr;
            sel_wdata = sel ? m1_wdata : m0_wdata;
            wr_d      = sel_wr;
            off       = sel_addr[1:0];

            data_sram_en   = 1'b1;
            data_sram_addr = {sel_addr[31:2], 2'b00};
            if (sel_wr) begin
               case (sel_size)
                  2'b01: begin
                     data_sram_wen   = 4'b0001 << off;
                     data_sram_wdata = sel_wdata << {off, 3'b000};
                  end
                  2'b10: begin
                     data_sram_wen   = 4'b0011 << off;
                     data_sram_wdata = sel_wdata << {off, 3'b000};
                  end
                  // 2'b00 is illegal and handled as a word.
                  default: begin
                     data_sram_wen   = 4'b1111;
                     data_sram_wdata = sel_wdata;
                  end
               endcase
            end

`ifdef DMEM_ARB_ADDR_ERR_EN
            mis = ((sel_size == 2'b10) && off[0]) ||
                  ((sel_size[1] == sel_size[0]) && (off != 2'b00));
            if (mis) begin
               data_sram_en    = 1'b0;
               data_sram_wen   = 4'b0000;
               data_sram_wdata = 32'h0;
            end
            err_d = mis;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         prio_q  <= (RESET_PRIO != 0);
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed self-checking bench for dmem_arb (RESET_PRIO = 0).
module tb_dmem_arb;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req, m0_wr, m1_wr;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

   int n_chk = 0;
   int n_fail = 0;

   // Store lane-steering vectors for m1: size, addr, wdata -> wen, sram wdata, sram addr.
   logic [1:0]  v_size  [0:4] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01};
   logic [31:0] v_addr  [0:4] = '{32'h2, 32'h8, 32'hC, 32'h7, 32'h4};
   logic [31:0] v_wdata [0:4] = '{32'h1234, 32'hCAFEF00D, 32'h55AA55AA, 32'h1FF, 32'h12345678};
   logic [3:0]  e_wen   [0:4] = '{4'b1100, 4'b1111, 4'b1111, 4'b1000, 4'b0001};
   logic [31:0] e_wdata [0:4] = '{32'h12340000, 32'hCAFEF00D, 32'h55AA55AA, 32'hFF000000,
                                  32'h12345678};
   logic [31:0] e_addr  [0:4] = '{32'h0, 32'h8, 32'hC, 32'h4, 32'h4};

   dmem_arb #(.RESET_PRIO(0)) dut (
      .clk             (clk),
      .reset           (reset),
      .m0_req          (m0_req),
      .m0_wr           (m0_wr),
      .m0_size         (m0_size),
      .m0_addr         (m0_addr),
      .m0_wdata        (m0_wdata),
      .m0_gnt          (m0_gnt),
      .m0_rvalid       (m0_rvalid),
      .m0_rdata        (m0_rdata),
      .m0_err          (m0_err),
      .m1_req          (m1_req),
      .m1_wr           (m1_wr),
      .m1_size         (m1_size),
      .m1_addr         (m1_addr),
      .m1_wdata        (m1_wdata),
      .m1_gnt          (m1_gnt),
      .m1_rvalid       (m1_rvalid),
      .m1_rdata        (m1_rdata),
      .m1_err          (m1_err),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
      m0_size = 2'b11; m1_size = 2'b11;
      m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
      data_sram_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      reset = 0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      m0_req = 1; m1_req = 1; m0_wr = 1; m1_wr = 1;
      m0_addr = 32'h44; m1_addr = 32'h88; m0_wdata = 32'hFFFF; m1_wdata = 32'hFFFF;
      data_sram_rdata = 32'hFFFFFFFF;
      tick();
      tick();
      n_chk++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin
         n_fail++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
      end
      n_chk++;
      if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_rsp: got %b want 0000",
                            {m0_rvalid, m1_rvalid, m0_err, m1_err});
      end
      n_chk++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
      end
      n_chk++;
      if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== 69'h0) begin
         n_fail++; $display("FAIL reset_sram: en %b wen %b addr %h wdata %h want all 0",
                            data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
      end
      reset = 0;
      clear_inputs();
      #1;
   endtask

   task automatic test_byte_store();
      do_reset();
      m0_req = 1; m0_wr = 1; m0_size = 2'b01; m0_addr = 32'h1002; m0_wdata = 32'hAB;
      #1;
      n_chk++;
      if ({m0_gnt, m1_gnt, data_sram_en} !== 3'b101) begin
         n_fail++; $display("FAIL bstore_gnt: got gnt %b%b en %b want 10 1",
                            m0_gnt, m1_gnt, data_sram_en);
      end
      n_chk++;
      if (data_sram_wen !== 4'b0100) begin
         n_fail++; $display("FAIL bstore_wen: got %b want 0100", data_sram_wen);
      end
      n_chk++;
      if (data_sram_wdata !== 32'h00AB0000) begin
         n_fail++; $display("FAIL bstore_wdata: got %h want 00ab0000", data_sram_wdata);
      end
      n_chk++;
      if (data_sram_addr !== 32'h1000) begin
         n_fail++; $display("FAIL bstore_addr: got %h want 00001000", data_sram_addr);
      end
      tick();
      clear_inputs();
      data_sram_rdata = 32'hFFFFFFFF;
      #1;
      n_chk++;
      if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL bstore_rsp: got rvalid %b%b rdata %h want 10 00000000",
                            m0_rvalid, m1_rvalid, m0_rdata);
      end
      n_chk++;
      if ({data_sram_en, data_sram_wen, data_sram_wdata} !== 37'h0) begin
         n_fail++; $display("FAIL idle_sram: en %b wen %b wdata %h want 0",
                            data_sram_en, data_sram_wen, data_sram_wdata);
      end
      tick();
      n_chk++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL bstore_pulse: got rvalid %b%b want 00", m0_rvalid, m1_rvalid);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         m0_req = (i < 4); m1_req = (i < 4);
         m0_addr = 32'h100 + 32'(i * 4); m1_addr = 32'h200 + 32'(i * 4);
         data_sram_rdata = 32'h5000 + 32'(i);
         #1;
         if (i < 4) begin
            n_chk++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b want %s", i, m0_gnt, m1_gnt,
                                  (i % 2 == 0) ? "10" : "01");
            end
         end
         if (i > 0) begin
            n_chk++;
            if ({m0_rvalid, m1_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL rr_rvalid[%0d]: got %b%b", i, m0_rvalid, m1_rvalid);
            end
            n_chk++;
            if ((((i - 1) % 2 == 0) ? m0_rdata : m1_rdata) !== 32'h5000 + 32'(i)) begin
               n_fail++; $display("FAIL rr_rdata[%0d]: got %h %h want %h", i, m0_rdata,
                                  m1_rdata, 32'h5000 + 32'(i));
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_store_lanes();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         m1_req = 1; m1_wr = 1;
         m1_size = v_size[i]; m1_addr = v_addr[i]; m1_wdata = v_wdata[i];
         data_sram_rdata = 32'hA5A5A5A5;
         #1;
         n_chk++;
         if ({m1_gnt, m0_gnt, data_sram_en} !== 3'b101 || data_sram_wen !== e_wen[i] ||
             data_sram_wdata !== e_wdata[i] || data_sram_addr !== e_addr[i]) begin
            n_fail++; $display("FAIL lanes[%0d]: gnt %b en %b wen %b wdata %h addr %h want wen %b wdata %h addr %h",
                               i, m1_gnt, data_sram_en, data_sram_wen, data_sram_wdata,
                               data_sram_addr, e_wen[i], e_wdata[i], e_addr[i]);
         end
         if (i > 0) begin
            n_chk++;
            if ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== 32'h0) begin
               n_fail++; $display("FAIL lanes_rsp[%0d]: rvalid %b%b rdata %h want 10 0", i,
                                  m1_rvalid, m0_rvalid, m1_rdata);
            end
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_m1();
      do_reset();
      m1_req = 1; m1_wr = 0; m1_size = 2'b11; m1_addr = 32'h20; m1_wdata = 32'hFFFFFFFF;
      #1;
      n_chk++;
      if ({m1_gnt, data_sram_en} !== 2'b11 || data_sram_wen !== 4'b0000 ||
          data_sram_wdata !== 32'h0 || data_sram_addr !== 32'h20) begin
         n_fail++; $display("FAIL load_issue: gnt %b en %b wen %b wdata %h addr %h want 1 1 0000 0 20",
                            m1_gnt, data_sram_en, data_sram_wen, data_sram_wdata, data_sram_addr);
      end
      tick();
      clear_inputs();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      n_chk++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m1_err !== 1'b0) begin
         n_fail++; $display("FAIL load_rsp: rvalid %b rdata %h err %b want 1 deadbeef 0",
                            m1_rvalid, m1_rdata, m1_err);
      end
      n_chk++;
      if ({m0_gnt, m0_rvalid, m0_err} !== 3'b000 || m0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL load_m0_quiet: gnt %b rvalid %b err %b rdata %h want 0",
                            m0_gnt, m0_rvalid, m0_err, m0_rdata);
      end
      tick();
   endtask

   task automatic test_misaligned_half();
      do_reset();
      m0_req = 1; m0_wr = 0; m0_size = 2'b10; m0_addr = 32'h3;
      #1;
      n_chk++;
`ifdef DMEM_ARB_ADDR_ERR_EN
      if ({m0_gnt, data_sram_en} !== 2'b10 || data_sram_wen !== 4'b0000) begin
         n_fail++; $display("FAIL mis_issue: gnt %b en %b wen %b want 1 0 0000",
                            m0_gnt, data_sram_en, data_sram_wen);
      end
`else
      if ({m0_gnt, data_sram_en} !== 2'b11 || data_sram_addr !== 32'h0) begin
         n_fail++; $display("FAIL mis_issue: gnt %b en %b addr %h want 1 1 0",
                            m0_gnt, data_sram_en, data_sram_addr);
      end
`endif
      tick();
      clear_inputs();
      data_sram_rdata = 32'h13579BDF;
      #1;
      n_chk++;
`ifdef DMEM_ARB_ADDR_ERR_EN
      if ({m0_rvalid, m0_err} !== 2'b11 || m0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL mis_rsp: rvalid %b err %b rdata %h want 1 1 0",
                            m0_rvalid, m0_err, m0_rdata);
      end
`else
      if ({m0_rvalid, m0_err} !== 2'b10 || m0_rdata !== 32'h13579BDF) begin
         n_fail++; $display("FAIL mis_rsp: rvalid %b err %b rdata %h want 1 0 13579bdf",
                            m0_rvalid, m0_err, m0_rdata);
      end
`endif
      tick();
   endtask

   task automatic test_reset_discard();
      do_reset();
      m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
      #1;
      n_chk++;
      if (m0_gnt !== 1'b1) begin
         n_fail++; $display("FAIL discard_gnt: got %b want 1", m0_gnt);
      end
      tick();
      clear_inputs();
      reset = 1;
      data_sram_rdata = 32'hFEEDFACE;
      #1;
      n_chk++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL discard_in_reset: rvalid %b%b rdata %h want 00 0",
                            m0_rvalid, m1_rvalid, m0_rdata);
      end
      tick();
      reset = 0;
      #1;
      n_chk++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL discard_after: rvalid %b%b want 00", m0_rvalid, m1_rvalid);
      end
      // The pre-reset grant moved the pointer to m1; reset must restore preference to m0.
      m0_req = 1; m1_req = 1;
      #1;
      n_chk++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL discard_prio: gnt %b%b want 10", m0_gnt, m1_gnt);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      test_reset();
      test_byte_store();
      test_round_robin();
      test_store_lanes();
      test_load_m1();
      test_misaligned_half();
      test_reset_discard();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 The block SHALL have parameter RESET_PRIO, default 0, selecting the requester preferred on the first contended cycle after reset (0 = m0, 1 = m1).
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Ports m0_req / m1_req, input, 1, the requester has an access pending.
REQ-005 Ports m0_wr / m1_wr, input, 1, 1 = store, 0 = load.
REQ-006 Ports m0_size / m1_size, input, 2, access size: 01 byte, 10 half, 11 word, 00 illegal (treated as word).
REQ-007 Ports m0_addr / m1_addr, input, 32, byte address.
REQ-008 Ports m0_wdata / m1_wdata, input, 32, store data, right-aligned.
REQ-009 Ports m0_gnt / m1_gnt, output, 1, request accepted this cycle.
REQ-010 Ports m0_rvalid / m1_rvalid, output, 1, one-cycle response pulse.
REQ-011 Ports m0_rdata / m1_rdata, output, 32, raw SRAM word for a load response; 0 otherwise.
REQ-012 Ports m0_err / m1_err, output, 1, response carries an alignment error.
REQ-013 Port data_sram_en, output, 1, SRAM access strobe.
REQ-014 Port data_sram_wen, output, 4, byte write enables.
REQ-015 Port data_sram_addr, output, 32, word address {addr[31:2],2'b00}.
REQ-016 Port data_sram_wdata, output, 32, lane-steered store data.
REQ-017 Port data_sram_rdata, input, 32, read data, valid exactly one cycle after a read strobe.

Function
REQ-018 The FSM SHALL have states IDLE (no response owed) and BUSY (one response owed next cycle); a grant in either state goes to BUSY, no grant goes to IDLE.
REQ-019 At most one grant per cycle; gnt SHALL be combinational from req and the priority pointer, and a request is accepted in any cycle including BUSY (throughput one access per cycle).
REQ-020 With a single requester it SHALL be granted; with both requesting, the pointer-preferred one SHALL be granted and the pointer SHALL then point to the other requester.
REQ-021 A grant with no contention SHALL also move the pointer to the non-granted requester.
REQ-022 On grant the block SHALL drive data_sram_en=1 and the granted requester's address in the same cycle; the requester's inputs are sampled only in the grant cycle.
REQ-023 Byte store: wen = 0001 << addr[1:0], wdata = wdata << 8*addr[1:0].
REQ-024 Half store: wen = (0011 << addr[1:0]) truncated to 4 bits, wdata shifted the same way.
REQ-025 Word store: wen = 1111, wdata unshifted.
REQ-026 Load: wen = 0000, wdata = 0.
REQ-027 With no grant: en = 0, wen = 0000, wdata = 0.
REQ-028 Exactly one cycle after each grant, the owner's rvalid SHALL pulse for one cycle with rdata = data_sram_rdata for a load, and rdata = 0 for a store.
REQ-029 The non-owner's rvalid, rdata and err SHALL be 0.
REQ-030 A BUSY cycle with a new grant SHALL emit the old response and issue the new access simultaneously.

Reset
REQ-031 While reset is high: all gnt, rvalid, err and data_sram_en SHALL be 0; rdata, wen, wdata and addr SHALL be 0; state = IDLE; pointer = RESET_PRIO.
REQ-032 A response owed when reset asserts SHALL be discarded and never emitted.
REQ-033 No grant is issued in the reset cycle.

Configuration
REQ-034 With macro DMEM_ARB_ADDR_ERR_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=00) SHALL still be granted and advance the pointer, but SHALL drive data_sram_en=0 and wen=0000; its response SHALL carry err=1 and rdata=0.
REQ-035 Without DMEM_ARB_ADDR_ERR_EN, misaligned accesses SHALL be issued per REQ-023..REQ-026, and both err outputs SHALL be constant 0.

Verification
REQ-036 Reset, then m0 byte store, addr=0x1002, wdata=0xAB -> m0_gnt=1; wen=0100, wdata=0x00AB0000, sram addr=0x1000; m0_rvalid=1 next cycle with rdata=0.
REQ-037 Both req every cycle, 4 cycles, RESET_PRIO=0 -> grants in order m0, m1, m0, m1; one rvalid per cycle from cycle 2 to the matching owner.
REQ-038 m1 word load at addr=0x20, SRAM returns 0xDEADBEEF next cycle -> m1_rvalid=1, m1_rdata=0xDEADBEEF; m0 outputs all 0.
REQ-039 Half load, addr=0x3, with macro -> gnt=1, en=0, next cycle err=1, rdata=0; without macro -> en=1, err=0.
REQ-040 Grant m0 load, then assert reset in the following cycle -> no m0_rvalid ever; the next contended request after reset is granted to RESET_PRIO.
